// File: rtl/lcd_i2c_master.sv
// rtl/lcd_i2c_master.sv - byte-level I2C master for the LCD control bus, Avalon-MM register slave
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   address, chipselect,         register access: 0 DATA, 1 CMD, 2 STATUS, 3 DIV
//   write_n, writedata
//   readdata                     registered read mux (1-cycle latency)
//   irq                          mirrors STATUS.done
//   scl_oe, sda_oe               open-drain enables (1 pulls the line low)
//   scl_in, sda_in               synchronised pin levels

module lcd_i2c_master #(
  parameter logic [7:0] DIV_RESET = 8'd124
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       irq,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_XFER, S_ACK, S_STOP} state_t;

  state_t     state, state_nx;
  logic [7:0] div_q, tx, rx, sh, cnt;
  logic [1:0] qtr;
  logic [2:0] bit_cnt;
  logic       rx_nack, done, scl_hold;
  logic       c_stop, c_read, c_write, c_mack;

  logic wr_en, busy, cmd_go, rd_mode;
  logic stretch_q, hold, q_end, ph_end, sample;
  logic bit_low;

  assign wr_en   = chipselect & ~write_n;
  assign busy    = (state != S_IDLE);
  assign cmd_go  = wr_en && (address == 2'd1) && !busy && (writedata[3:0] != 4'd0);
  // WRITE takes precedence when both transfer directions are requested
  assign rd_mode = c_read & ~c_write;
  assign irq     = done;

  // Quarters in which SCL is released; a slave may stretch by holding it low
  always_comb begin
    stretch_q = 1'b0;
    case (state)
      S_START:       stretch_q = (qtr <= 2'd1);
      S_XFER, S_ACK: stretch_q = (qtr == 2'd1) || (qtr == 2'd2);
      S_STOP:        stretch_q = (qtr != 2'd0);
      default:       stretch_q = 1'b0;
    endcase
  end

  assign hold   = stretch_q && !scl_in;
  assign q_end  = busy && !hold && (cnt == div_q);
  assign ph_end = q_end && (qtr == 2'd3);
  assign sample = q_end && (qtr == 2'd2);

  function automatic state_t after_start(input logic w, input logic r, input logic s);
    if (w || r)
      after_start = S_XFER;
    else if (s)
      after_start = S_STOP;
    else
      after_start = S_IDLE;
  endfunction

  // State register plus quarter/bit timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      qtr     <= 2'd0;
      bit_cnt <= 3'd0;
    end else begin
      state <= state_nx;
      if (!busy) begin
        cnt     <= 8'd0;
        qtr     <= 2'd0;
        bit_cnt <= 3'd0;
      end else if (hold) begin
        cnt <= 8'd0;
      end else if (q_end) begin
        cnt <= 8'd0;
        qtr <= qtr + 2'd1;
        if (state == S_XFER && qtr == 2'd3)
          bit_cnt <= bit_cnt + 3'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Next state and open-drain enables
  always_comb begin
    state_nx = state;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    bit_low  = 1'b0;

    if (state == S_XFER)
      bit_low = rd_mode ? 1'b0 : ~sh[7];
    else if (state == S_ACK)
      bit_low = rd_mode ? ~c_mack : 1'b0;

    case (state)
      S_IDLE: begin
        scl_oe = scl_hold;
        if (cmd_go)
          state_nx = writedata[0] ? S_START
                                  : after_start(writedata[3], writedata[2], writedata[1]);
      end
      S_START: begin
        sda_oe = (qtr != 2'd0);
        scl_oe = qtr[1];
        if (ph_end)
          state_nx = after_start(c_write, c_read, c_stop);
      end
      S_XFER: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe = bit_low;
        if (ph_end && bit_cnt == 3'd7)
          state_nx = S_ACK;
      end
      S_ACK: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe = bit_low;
        if (ph_end)
          state_nx = c_stop ? S_STOP : S_IDLE;
      end
      S_STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = (qtr <= 2'd1);
        if (ph_end)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registers, shift paths and read mux
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= DIV_RESET;
      tx       <= 8'd0;
      rx       <= 8'd0;
      sh       <= 8'd0;
      rx_nack  <= 1'b0;
      done     <= 1'b0;
      scl_hold <= 1'b0;
      c_stop   <= 1'b0;
      c_read   <= 1'b0;
      c_write  <= 1'b0;
      c_mack   <= 1'b0;
      readdata <= 8'd0;
    end else begin
      if (wr_en && !busy) begin
        if (address == 2'd0) tx    <= writedata;
        if (address == 2'd3) div_q <= writedata;
      end

      if (cmd_go) begin
        c_stop  <= writedata[1];
        c_read  <= writedata[2];
        c_write <= writedata[3];
        c_mack  <= writedata[4];
        sh      <= tx;
      end

      if (state == S_XFER && sample && rd_mode)
        rx <= {rx[6:0], sda_in};
      if (state == S_ACK && sample && !rd_mode)
        rx_nack <= sda_in;
      if (state == S_XFER && ph_end)
        sh <= {sh[6:0], 1'b0};

      // Completion wins over a simultaneous STATUS clear
      if (busy && state_nx == S_IDLE) begin
        done     <= 1'b1;
        scl_hold <= (state != S_STOP);
      end else if (wr_en && address == 2'd2) begin
        done <= 1'b0;
      end

      case (address)
        2'd0:    readdata <= rx;
        2'd1:    readdata <= 8'd0;
        2'd2:    readdata <= {5'd0, done, rx_nack, busy};
        default: readdata <= div_q;
      endcase
    end
  end

endmodule

// File: doc/lcd_i2c_master.md
# lcd_i2c_master

Byte-level I2C master for the LCD control bus, built to replace software bit-banging of the SCL/SDA PIOs. It is an Avalon-MM slave: the CPU loads a byte and issues a command (START / WRITE / READ / STOP in any combination). The block sequences SCL and SDA through open-drain enables, with programmable bit rate and SCL clock-stretching support. It sits between the Avalon interconnect and the LCD I2C pins, with tri-state buffers at top level.

## Interface
- DIV_RESET, 124: reset value of the quarter-bit divisor. Quarter period = DIV+1 clk cycles (124 at 50 MHz gives 100 kHz).
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select: 0 DATA, 1 CMD, 2 STATUS, 3 DIV
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  8  write data
- readdata  out  8  registered read data
- irq  out  1  high while STATUS.done = 1
- scl_oe  out  1  1 drives SCL low, 0 releases it
- sda_oe  out  1  1 drives SDA low, 0 releases it
- scl_in  in  1  SCL pin level (already synchronised)
- sda_in  in  1  SDA pin level (already synchronised)

## Operation
**Register writes** (write = chipselect & ~write_n):
- DATA: sets tx byte.
- CMD bits: [0] START, [1] STOP, [2] READ, [3] WRITE, [4] MACK (1 = master sends NACK after READ).
- STATUS: any value clears done.
- DIV: sets the divisor.
- Writes to DATA, CMD and DIV while busy = 1 are ignored.

**Register reads:**
- DATA: rx byte.
- STATUS: [0] busy, [1] rx_nack (last slave ACK bit, 1 = NACK), [2] done.
- DIV: current divisor.
- CMD: reads 0.
- readdata is updated every clk from address (read mux registered, 1-cycle latency).

**Command sequencing:**
- Phases execute in fixed order: START → (WRITE | READ) → STOP.
- If both WRITE and READ are set, WRITE runs and READ is ignored.
- A CMD with none of bits 0–3 set is a no-op: busy stays 0 and done is unchanged.

**FSM states:** IDLE, START, XFER (8 bits, MSB first), ACK (1 bit), STOP.
- IDLE → first requested phase on a valid CMD write.
- Each phase → next requested phase, else → IDLE.
- Entering IDLE from any active phase sets done.
- busy = 1 in every state except IDLE.

**Quarter phases.** Every phase is 4 quarters, q0–q3.
- START: q0 both released; q1 sda_oe = 1; q2 scl_oe = 1; q3 hold.
- XFER/ACK bit:
  - q0: scl_oe = 1, sda_oe set to the bit value.
  - q1, q2: scl released.
  - q3: scl_oe = 1.
  - sda_in is sampled on the last cycle of q2.
- Bit values by phase:
  - WRITE: sda_oe = ~tx bit; the ACK bit releases SDA and captures rx_nack.
  - READ: SDA released for all 8 bits, shifted into rx; the ACK bit has sda_oe = ~MACK.
- STOP: q0 scl_oe = 1, sda_oe = 1; q1 scl released; q2 sda released; q3 hold.
- After STOP both lines are released. After a phase without STOP, SCL is held low (scl_oe = 1) in IDLE until the next command.

**Clock stretching:** in any quarter where scl is released (START q0–q1, bit q1–q2, STOP q1–q3), the quarter counter holds at 0 while scl_in = 0. Counting resumes on the first cycle scl_in = 1.

## Timing
- Reset values:
  - scl_oe = 0, sda_oe = 0 (both lines released immediately, including mid-transfer).
  - readdata = 0, irq = 0.
  - DIV = DIV_RESET; tx, rx, rx_nack, done, busy = 0; FSM in IDLE.
- busy rises on the clk edge after the accepting CMD write.
- Quarter counter runs 0..DIV. A quarter ends when counter == DIV, so each quarter is DIV+1 cycles with no stretching.
- DIV = 0 is legal: each quarter is 1 cycle.
- Unstretched phase lengths:
  - START, STOP: 4(DIV+1) cycles each.
  - WRITE or READ: 36(DIV+1) cycles.
- Last cycle of the final phase: the next edge sets busy = 0 and done = 1 simultaneously. irq follows done in the same cycle.
- A STATUS write coinciding with completion leaves done = 1 (set wins).
- rx and rx_nack are valid when busy falls and hold until the next transfer's ACK/bit capture.

## Test plan
- Reset, then read DIV and STATUS → 124 and 0x00. scl_oe = 0, sda_oe = 0, irq = 0.
- DIV = 1, DATA = 0xA5, CMD = 0x0B (START | WRITE | STOP), slave model ACKs → SDA waveform 1010_0101, ACK sampled 0. busy high for 44×2 = 88 cycles, then STATUS = 0x04, irq = 1, both lines released. STATUS write clears irq.
- DIV = 0, CMD = 0x14 (READ | MACK) after an open START, slave sends 0x3C → DATA reads 0x3C; master leaves SDA released on the ACK bit; SCL held low afterwards.
- Slave NACKs address byte 0x78 → STATUS.rx_nack = 1 and done = 1.
- Slave holds scl_in low for 50 cycles in bit 3 q1 → transfer lengthens by exactly 50 cycles and data is still correct.
- During a busy WRITE: write DIV = 7 and DATA = 0xFF (both ignored, DIV reads 1); then assert reset_n = 0 mid-byte → outputs released in the same cycle and busy = 0.
